cdb_writeback_arbiter: RTL and testbench
========================================

Name: cdb_writeback_arbiter

Overview:
Parametrised common-data-bus write-back stage for the Tomasulo core. It accepts completed results from NUM_SRC execution units over valid/ready handshakes and grants one producer per cycle, using round-robin or fixed priority. The winner is broadcast on a registered CDB (tag + data) that drives the ROB value write and reservation-station operand wakeup. It also pulses a per-source "unit free" strobe and keeps a saturating contention counter.

Parameters:
NUM_SRC, 3, number of producer channels (execution units); 2..8
DATA_W, 32, result width
TAG_W, 3, ROB index width (tag broadcast on CDB)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
CNT_W, 16, width of contention counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  pipeline flush; drops in-flight broadcast, blocks acceptance this cycle
src_valid  in  NUM_SRC  per-source result valid
src_ready  out  NUM_SRC  per-source grant/accept (combinational)
src_tag  in  NUM_SRC*TAG_W  per-source ROB index, source i at [i*TAG_W +: TAG_W]
src_data  in  NUM_SRC*DATA_W  per-source result value, source i at [i*DATA_W +: DATA_W]
cdb_valid  out  1  broadcast valid
cdb_tag  out  TAG_W  broadcast ROB index
cdb_data  out  DATA_W  broadcast value
cdb_src  out  $clog2(NUM_SRC)  index of the source being broadcast
unit_free  out  NUM_SRC  one-cycle pulse; source's execution unit released
contention_cnt  out  CNT_W  saturating count of cycles with ≥2 src_valid and no flush

Behaviour:
- Reset (rst_n=0 sampled at clk): cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, unit_free=0, contention_cnt=0, rr_ptr=0. While rst_n=0, src_ready=0.
- Grant (combinational):
  - ARB_MODE=0: first i with src_valid[i]=1 scanning rr_ptr, rr_ptr+1, … with wrap mod NUM_SRC.
  - ARB_MODE=1: lowest i with src_valid[i]=1.
  - src_ready is one-hot or zero; zero when flush=1, rst_n=0, or no src_valid.
- Transfer: occurs when src_valid[i] & src_ready[i].
  - Next edge: cdb_valid=1, cdb_tag=src_tag[i], cdb_data=src_data[i], cdb_src=i, unit_free=(1<<i).
- Latency: exactly 1 cycle from accept to broadcast. Back-to-back transfers every cycle are allowed, with no bubble.
- No transfer: cdb_valid=0 and unit_free=0 the next cycle. cdb_tag, cdb_data, and cdb_src hold their last values.
- rr_ptr (ARB_MODE=0): after a transfer from source i, rr_ptr <= (i+1) mod NUM_SRC. It is unchanged otherwise and ignored in ARB_MODE=1.
- Producers must hold valid, tag, and data stable until accepted. The arbiter imposes no ordering between sources.
- Flush: src_ready=0 during that cycle. Next edge: cdb_valid=0, unit_free=0, rr_ptr=0. contention_cnt does not increment that cycle.
- Flush does not clear a broadcast already visible: a cdb_valid=1 present in the flush cycle stays visible for that cycle only.
- Contention: if popcount(src_valid)≥2 and flush=0, contention_cnt increments by 1. It saturates at 2^CNT_W−1 and never wraps.
- Simultaneous equal tags from two sources are not detected. Each is broadcast in its own cycle, in grant order.
- Reset mid-stream: the pending broadcast is discarded and all state returns to reset values at that edge.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with src_valid=3'b111 -> src_ready=0, cdb_valid=0, contention_cnt=0. Release -> src0 granted first (rr_ptr=0).
- Single source: src_valid[1]=1, tag=5, data=32'hDEADBEEF for one cycle -> src_ready[1]=1 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_data=DEADBEEF, cdb_src=1, unit_free=3'b010; following cycle cdb_valid=0.
- Round-robin fairness, ARB_MODE=0, all three valid continuously -> grants 0,1,2,0,1,2; cdb_valid=1 every cycle after the first; contention_cnt increments every cycle.
- Fixed priority, ARB_MODE=1, all valid for 3 cycles then src0 drops -> grants 0,0,0 then 1. src2 is starved while src1 is valid.
- Flush: src_valid=3'b110 with flush=1 -> src_ready=0; next cycle cdb_valid=0; rr_ptr=0, so the next grant is src1 (first valid from index 0).
- Saturation: CNT_W=4, 20 cycles with two sources valid -> contention_cnt stops at 15.

Source files
------------

// File: rtl/cdb_writeback_arbiter.sv
// Common-data-bus write-back arbiter: grants one producer per cycle (round-robin or fixed
// priority) and broadcasts its tag/data on a registered CDB one cycle after acceptance.
module cdb_writeback_arbiter #(
    parameter int unsigned NUM_SRC  = 3,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 3,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]      src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    output logic                          cdb_valid,
    output logic [TAG_W-1:0]              cdb_tag,
    output logic [DATA_W-1:0]             cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]    cdb_src,
    output logic [NUM_SRC-1:0]            unit_free,
    output logic [CNT_W-1:0]              contention_cnt
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);

    logic [SRC_W-1:0]   rr_ptr_q;
    logic [SRC_W-1:0]   grant_idx;
    logic [NUM_SRC-1:0] grant;
    logic               found;
    logic               xfer;
    logic               contend;

    logic               cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [DATA_W-1:0]  cdb_data_q;
    logic [SRC_W-1:0]   cdb_src_q;
    logic [NUM_SRC-1:0] unit_free_q;
    logic [CNT_W-1:0]   cnt_q;

    // Scan starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
    always_comb begin
        int unsigned idx;
        int unsigned start;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        start     = (ARB_MODE == 0) ? int'(rr_ptr_q) : 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = start + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && src_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
    end

    assign src_ready = (rst_n && !flush && found) ? grant : '0;
    assign xfer      = |src_ready;
    assign contend   = ($countones(src_valid) >= 2) && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            unit_free_q <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
        end else begin
            cdb_valid_q <= xfer;
            unit_free_q <= src_ready;
            if (xfer) begin
                cdb_tag_q  <= src_tag[grant_idx*TAG_W +: TAG_W];
                cdb_data_q <= src_data[grant_idx*DATA_W +: DATA_W];
                cdb_src_q  <= grant_idx;
            end
            if (flush) begin
                rr_ptr_q <= '0;
            end else if (xfer && ARB_MODE == 0) begin
                rr_ptr_q <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
            end
            if (contend && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cdb_valid      = cdb_valid_q;
    assign cdb_tag        = cdb_tag_q;
    assign cdb_data       = cdb_data_q;
    assign cdb_src        = cdb_src_q;
    assign unit_free      = unit_free_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench: a round-robin instance (16-bit counter) and a fixed-priority instance
// (4-bit counter) share one stimulus stream; expectations are hand-computed.
module tb_cdb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  src_valid;
    logic [8:0]  src_tag;
    logic [95:0] src_data;

    logic [2:0]  ready_r, ready_f;
    logic        cv_r, cv_f;
    logic [2:0]  ctag_r, ctag_f;
    logic [31:0] cdata_r, cdata_f;
    logic [1:0]  csrc_r, csrc_f;
    logic [2:0]  free_r, free_f;
    logic [15:0] cnt_r;
    logic [3:0]  cnt_f;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    cdb_writeback_arbiter #(
        .NUM_SRC(3), .DATA_W(32), .TAG_W(3), .ARB_MODE(0), .CNT_W(16)
    ) u_rr (
        .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(src_valid),
        .src_ready(ready_r), .src_tag(src_tag), .src_data(src_data),
        .cdb_valid(cv_r), .cdb_tag(ctag_r), .cdb_data(cdata_r), .cdb_src(csrc_r),
        .unit_free(free_r), .contention_cnt(cnt_r)
    );

    cdb_writeback_arbiter #(
        .NUM_SRC(3), .DATA_W(32), .TAG_W(3), .ARB_MODE(1), .CNT_W(4)
    ) u_fp (
        .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(src_valid),
        .src_ready(ready_f), .src_tag(src_tag), .src_data(src_data),
        .cdb_valid(cv_f), .cdb_tag(ctag_f), .cdb_data(cdata_f), .cdb_src(csrc_f),
        .unit_free(free_f), .contention_cnt(cnt_f)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = 3'b111;
        src_tag   = {3'd3, 3'd2, 3'd1};
        src_data  = {32'hC, 32'hB, 32'hA};

        // Reset held for two edges with all sources valid
        step();
        step();
        check("rst_ready_r", 64'(ready_r), 64'd0);
        check("rst_ready_f", 64'(ready_f), 64'd0);
        check("rst_cv_r", 64'(cv_r), 64'd0);
        check("rst_cnt_r", 64'(cnt_r), 64'd0);
        check("rst_cnt_f", 64'(cnt_f), 64'd0);

        // Round-robin fairness with all valid; fixed priority always picks 0
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready", 64'(ready_r), 64'(3'b001 << (k % 3)));
            check("fp_ready", 64'(ready_f), 64'd1);
            step();
            check("rr_cv", 64'(cv_r), 64'd1);
            check("rr_src", 64'(csrc_r), 64'(k % 3));
            check("rr_tag", 64'(ctag_r), 64'(k % 3 + 1));
            check("rr_data", 64'(cdata_r), 64'(32'hA + k % 3));
            check("rr_free", 64'(free_r), 64'(3'b001 << (k % 3)));
            check("rr_cnt", 64'(cnt_r), 64'(k + 1));
            check("fp_src", 64'(csrc_f), 64'd0);
        end

        // src0 drops: fixed priority moves to src1
        src_valid = 3'b110;
        #1;
        check("fp_ready_1", 64'(ready_f), 64'b010);
        check("rr_ready_1", 64'(ready_r), 64'b010);
        step();
        check("fp_src_1", 64'(csrc_f), 64'd1);
        check("fp_free_1", 64'(free_f), 64'b010);
        check("cnt_r_7", 64'(cnt_r), 64'd7);

        // Flush: no grant, visible broadcast survives this cycle only
        flush = 1'b1;
        #1;
        check("fl_ready_r", 64'(ready_r), 64'd0);
        check("fl_ready_f", 64'(ready_f), 64'd0);
        check("fl_cv_vis", 64'(cv_r), 64'd1);
        step();
        check("fl_cv", 64'(cv_r), 64'd0);
        check("fl_free", 64'(free_r), 64'd0);
        check("fl_cnt", 64'(cnt_r), 64'd7);
        check("fl_tag_hold", 64'(ctag_r), 64'd2);
        flush = 1'b0;
        #1;
        check("fl_regrant", 64'(ready_r), 64'b010);
        step();
        check("fl_cnt_8", 64'(cnt_r), 64'd8);

        // Single source transfer
        src_valid = 3'b010;
        src_tag   = {3'd3, 3'd5, 3'd1};
        src_data  = {32'hC, 32'hDEADBEEF, 32'hA};
        #1;
        check("ss_ready", 64'(ready_r), 64'b010);
        step();
        src_valid = 3'b000;
        check("ss_cv", 64'(cv_r), 64'd1);
        check("ss_tag", 64'(ctag_r), 64'd5);
        check("ss_data", 64'(cdata_r), 64'hDEADBEEF);
        check("ss_src", 64'(csrc_r), 64'd1);
        check("ss_free", 64'(free_r), 64'b010);
        #1;
        check("idle_ready", 64'(ready_r), 64'd0);
        step();
        check("idle_cv", 64'(cv_r), 64'd0);
        check("idle_free", 64'(free_r), 64'd0);
        check("idle_tag_hold", 64'(ctag_r), 64'd5);
        check("idle_cnt", 64'(cnt_r), 64'd8);

        // Saturation of the 4-bit counter
        src_valid = 3'b011;
        for (int k = 0; k < 20; k++) begin
            step();
        end
        check("sat_cnt_f", 64'(cnt_f), 64'd15);
        check("sat_cnt_r", 64'(cnt_r), 64'd28);

        // Reset mid-stream
        rst_n = 1'b0;
        #1;
        check("mr_ready", 64'(ready_r), 64'd0);
        step();
        check("mr_cv", 64'(cv_r), 64'd0);
        check("mr_cnt", 64'(cnt_r), 64'd0);
        check("mr_tag", 64'(ctag_r), 64'd0);
        check("mr_data", 64'(cdata_r), 64'd0);
        rst_n     = 1'b1;
        src_valid = 3'b110;
        #1;
        check("mr_grant", 64'(ready_r), 64'b010);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
